// File: rtl/sentinel_search_core.sv
// Buffered sentinel/key search engine: loads up to DEPTH words, scans LANES entries per cycle.
// Optional match counting enabled by defining SENTINEL_SEARCH_MATCH_COUNT_EN.
module sentinel_search_core #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned LANES  = 4,
   localparam int unsigned IDX_W = $clog2(DEPTH)
) (
   input  logic              ACLK,
   input  logic              ARESET,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_clear,
   input  logic              start,
   input  logic [DATA_W-1:0] key,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              found,
   output logic [IDX_W-1:0]  match_idx,
   output logic [IDX_W:0]    wr_count,
   input  logic              irq_enable,
   input  logic              irq_ack,
   output logic              irq_pending,
   output logic              irq
`ifdef SENTINEL_SEARCH_MATCH_COUNT_EN
   ,
   output logic [IDX_W:0]    match_cnt
`endif
);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StSearch = 2'd1;
   localparam logic [1:0] StDone   = 2'd2;

   logic [1:0]        state_q;
   logic [IDX_W:0]    wr_count_q;
   logic [IDX_W:0]    snap_q;
   logic [IDX_W:0]    base_q;
   logic [DATA_W-1:0] key_q;
   logic              found_q;
   logic [IDX_W-1:0]  match_idx_q;
   logic              pend_q;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              ld_fire;
   logic              hit_any;
   logic [IDX_W-1:0]  hit_idx;
   logic [IDX_W:0]    lane_idx;
   logic              last_blk;
`ifdef SENTINEL_SEARCH_MATCH_COUNT_EN
   logic [IDX_W:0]    hit_cnt;
   logic [IDX_W:0]    match_cnt_q;
`endif

   assign busy        = (state_q == StSearch);
   assign done        = (state_q == StDone);
   assign ld_ready    = !busy && (wr_count_q != (IDX_W+1)'(DEPTH));
   assign ld_fire     = ld_valid && ld_ready && !ld_clear;
   assign found       = found_q;
   assign match_idx   = match_idx_q;
   assign wr_count    = wr_count_q;
   assign irq_pending = pend_q;
   assign irq         = pend_q & irq_enable;
   assign last_blk    = (base_q + (IDX_W+1)'(LANES)) >= snap_q;

   // Descending lane walk so the lowest-index hit is the one left in hit_idx.
   always_comb begin
      hit_any  = 1'b0;
      hit_idx  = '0;
      lane_idx = '0;
`ifdef SENTINEL_SEARCH_MATCH_COUNT_EN
      hit_cnt  = '0;
`endif
      for (int l = LANES - 1; l >= 0; l--) begin
         lane_idx = base_q + (IDX_W+1)'(l);
         if (lane_idx < snap_q && mem[lane_idx[IDX_W-1:0]] == key_q) begin
            hit_any = 1'b1;
            hit_idx = lane_idx[IDX_W-1:0];
`ifdef SENTINEL_SEARCH_MATCH_COUNT_EN
            hit_cnt = hit_cnt + (IDX_W+1)'(1);
`endif
         end
      end
   end

   always_ff @(posedge ACLK) begin
      if (ld_fire) mem[wr_count_q[IDX_W-1:0]] <= ld_data;
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q     <= StIdle;
         wr_count_q  <= '0;
         snap_q      <= '0;
         base_q      <= '0;
         key_q       <= '0;
         found_q     <= 1'b0;
         match_idx_q <= '0;
         pend_q      <= 1'b0;
`ifdef SENTINEL_SEARCH_MATCH_COUNT_EN
         match_cnt_q <= '0;
`endif
      end else begin
         // A new completion wins over a same-cycle ack.
         pend_q <= (pend_q & ~irq_ack) | (state_q == StDone);

         if (ld_clear && !busy) wr_count_q <= '0;
         else if (ld_fire)      wr_count_q <= wr_count_q + (IDX_W+1)'(1);

         case (state_q)
            StIdle: begin
               if (start) begin
                  key_q       <= key;
                  base_q      <= '0;
                  found_q     <= 1'b0;
                  match_idx_q <= '0;
                  snap_q      <= wr_count_q;
`ifdef SENTINEL_SEARCH_MATCH_COUNT_EN
                  match_cnt_q <= '0;
`endif
                  state_q     <= (wr_count_q == '0) ? StDone : StSearch;
               end
            end
            StSearch: begin
               if (abort) begin
                  state_q <= StIdle;
                  found_q <= 1'b0;
               end else begin
`ifdef SENTINEL_SEARCH_MATCH_COUNT_EN
                  if (hit_any && !found_q) begin
                     found_q     <= 1'b1;
                     match_idx_q <= hit_idx;
                  end
                  match_cnt_q <= match_cnt_q + hit_cnt;
                  if (last_blk) state_q <= StDone;
                  else          base_q  <= base_q + (IDX_W+1)'(LANES);
`else
                  if (hit_any) begin
                     found_q     <= 1'b1;
                     match_idx_q <= hit_idx;
                     state_q     <= StDone;
                  end else if (last_blk) begin
                     found_q     <= 1'b0;
                     match_idx_q <= '0;
                     state_q     <= StDone;
                  end else begin
                     base_q <= base_q + (IDX_W+1)'(LANES);
                  end
`endif
               end
            end
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef SENTINEL_SEARCH_MATCH_COUNT_EN
   assign match_cnt = match_cnt_q;
`endif

endmodule

// File: tb/tb_sentinel_search_core.sv
// Randomised self-checking bench for sentinel_search_core against a queue-based search model.
module tb_sentinel_search_core;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 64;
   localparam int LANES  = 4;
   localparam int IDX_W  = 6;
   localparam int BUDGET = 100;

   logic              ACLK = 1'b0;
   logic              ARESET;
   logic              ld_valid, ld_ready, ld_clear, start, abort;
   logic [DATA_W-1:0] ld_data, key;
   logic              busy, done, found, irq_enable, irq_ack, irq_pending, irq;
   logic [IDX_W-1:0]  match_idx;
   logic [IDX_W:0]    wr_count;
`ifdef SENTINEL_SEARCH_MATCH_COUNT_EN
   logic [IDX_W:0]    match_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   logic [DATA_W-1:0] mdl_buf [$];

   sentinel_search_core #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LANES(LANES)) dut (
      .ACLK        (ACLK),
      .ARESET      (ARESET),
      .ld_valid    (ld_valid),
      .ld_ready    (ld_ready),
      .ld_data     (ld_data),
      .ld_clear    (ld_clear),
      .start       (start),
      .key         (key),
      .abort       (abort),
      .busy        (busy),
      .done        (done),
      .found       (found),
      .match_idx   (match_idx),
      .wr_count    (wr_count),
      .irq_enable  (irq_enable),
      .irq_ack     (irq_ack),
      .irq_pending (irq_pending),
      .irq         (irq)
`ifdef SENTINEL_SEARCH_MATCH_COUNT_EN
      ,
      .match_cnt   (match_cnt)
`endif
   );

   always #5 ACLK = ~ACLK;

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   // Acceptance decided by the model: not full and engine idle.
   task automatic load_word(input logic [DATA_W-1:0] d);
      bit exp_rdy;
      exp_rdy = (mdl_buf.size() != DEPTH);
      check("ld_ready", ld_ready, exp_rdy);
      ld_valid = 1'b1;
      ld_data  = d;
      step();
      ld_valid = 1'b0;
      if (exp_rdy) mdl_buf.push_back(d);
      check("wr_count_load", wr_count, mdl_buf.size());
   endtask

   task automatic clear_buf();
      ld_clear = 1'b1;
      step();
      ld_clear = 1'b0;
      mdl_buf.delete();
      check("wr_count_clear", wr_count, 0);
   endtask

   task automatic do_search(input logic [DATA_W-1:0] k, input int clear_at, input bit ack_in_done);
      bit exp_f;
      int exp_idx, exp_cnt, exp_lat, n, cyc;
      n = mdl_buf.size();
      exp_f = 0; exp_idx = 0; exp_cnt = 0;
      for (int i = 0; i < n; i++) begin
         if (mdl_buf[i] == k) begin
            if (!exp_f) begin exp_f = 1; exp_idx = i; end
            exp_cnt++;
         end
      end
`ifdef SENTINEL_SEARCH_MATCH_COUNT_EN
      exp_lat = (n == 0) ? 1 : (n + LANES - 1) / LANES + 1;
`else
      if (n == 0)     exp_lat = 1;
      else if (exp_f) exp_lat = exp_idx / LANES + 2;
      else            exp_lat = (n + LANES - 1) / LANES + 1;
`endif
      start = 1'b1;
      key   = k;
      step();
      start = 1'b0;
      key   = $urandom;
      cyc   = 1;
      while (!done && cyc < BUDGET) begin
         ld_clear = (cyc == clear_at);
         step();
         ld_clear = 1'b0;
         cyc++;
      end
      check("done_seen", done, 1);
      check("latency", cyc, exp_lat);
      check("found", found, exp_f);
      check("match_idx", match_idx, exp_idx);
      check("busy_in_done", busy, 0);
      check("wr_count_kept", wr_count, n);
`ifdef SENTINEL_SEARCH_MATCH_COUNT_EN
      check("match_cnt", match_cnt, exp_cnt);
`endif
      irq_ack = ack_in_done;
      step();
      irq_ack = 1'b0;
      check("done_pulse", done, 0);
      check("irq_pending_set", irq_pending, 1);
      check("irq_gate", irq, irq_enable);
   endtask

   task automatic ack_irq();
      irq_ack = 1'b1;
      step();
      irq_ack = 1'b0;
      check("irq_pending_ack", irq_pending, 0);
   endtask

   initial begin
      int dones;
      ARESET = 1'b1; ld_valid = 0; ld_clear = 0; start = 0; abort = 0;
      ld_data = '0; key = '0; irq_enable = 0; irq_ack = 0;
      repeat (3) step();
      ARESET = 1'b0;
      check("rst_wr_count", wr_count, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_found", found, 0);
      check("rst_match_idx", match_idx, 0);
      check("rst_irq_pending", irq_pending, 0);
      check("rst_irq", irq, 0);
      check("rst_ld_ready", ld_ready, 1);

      for (int i = 1; i <= 64; i++) load_word(DATA_W'(i));
      check("full_ready", ld_ready, 0);
      check("full_count", wr_count, 64);
      load_word(32'h41);
      check("full_no_wrap", wr_count, 64);

      do_search(32'h40, -1, 0);
      ack_irq();
      do_search(32'h100, 3, 0);
      ack_irq();

      clear_buf();
      for (int i = 0; i < 16; i++) load_word(32'hA0 + DATA_W'(i));
      irq_enable = 1'b1;
      do_search(32'hA9, -1, 0);
      ack_irq();

      irq_enable = 1'b0;
      do_search(32'hFF, -1, 0);
      check("irq_masked", irq, 0);
      irq_enable = 1'b1;
      #1;
      check("irq_unmasked", irq, 1);
      clear_buf();
      for (int i = 0; i < 16; i++) load_word((i == 3) ? 32'hA9 : 32'hA0 + DATA_W'(i));
      do_search(32'hA9, -1, 1);
      ack_irq();

      clear_buf();
      do_search(32'h5, -1, 0);
      ack_irq();

      for (int i = 0; i < 64; i++) load_word(32'h1000 + DATA_W'(i));
      start = 1'b1; key = 32'h5;
      step();
      start = 1'b0;
      step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_found", found, 0);
      dones = 0;
      for (int i = 0; i < 20; i++) begin
         if (done) dones++;
         step();
      end
      check("abort_no_done", dones, 0);
      check("abort_no_pending", irq_pending, 0);
      do_search(32'h1005, -1, 0);
      ack_irq();

      start = 1'b1; key = 32'h0;
      step();
      start = 1'b0;
      step();
      ARESET = 1'b1;
      step();
      ARESET = 1'b0;
      mdl_buf.delete();
      check("midrst_busy", busy, 0);
      check("midrst_wr_count", wr_count, 0);
      check("midrst_found", found, 0);

      for (int it = 0; it < 40; it++) begin
         int n;
         clear_buf();
         n = $urandom_range(0, 64);
         for (int i = 0; i < n; i++) load_word(DATA_W'($urandom_range(0, 7)));
         irq_enable = 1'($urandom_range(0, 1));
         do_search(DATA_W'($urandom_range(0, 8)), -1, 0);
         ack_irq();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
